// File: rtl/rdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rdiv_pkg
// Description : Shared types and constants for the restoring-division
//               sequencer: FSM state encoding, default operand width and
//               the iteration-count width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rdiv_pkg;

  // Default operand width; also the number of shift/subtract iterations.
  localparam int RDIV_WIDTH = 4;

  // Sequencer states, explicitly encoded in three bits.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_SUB     = 3'd3,
    ST_QSET    = 3'd4,
    ST_RESTORE = 3'd5,
    ST_DONE    = 3'd6
  } rdiv_state_t;

  // Width of a counter that must be able to hold the value WIDTH itself.
  function automatic int rdiv_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rdiv_if.sv
`default_nettype none
// ============================================================================
// Module      : rdiv_if
// Description : Handshake and control bundle between the restoring-division
//               sequencer and the host/datapath. The master side drives the
//               request and datapath status; the slave side is the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface rdiv_if import rdiv_pkg::*; #(
  parameter int WIDTH = RDIV_WIDTH
);

  localparam int CNT_W = rdiv_cnt_w(WIDTH);

  // Host / datapath to sequencer
  logic             start;
  logic             divisor_zero;
  logic             a_sign;

  // Sequencer to datapath / host
  logic             load_en;
  logic             shift_a_en;
  logic             sub_en;
  logic             shift_q_en;
  logic             restore_en;
  logic             busy;
  logic             done;
  logic             div_err;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output start, divisor_zero, a_sign,
    input  load_en, shift_a_en, sub_en, shift_q_en, restore_en,
    input  busy, done, div_err, iter_count
  );

  modport slave (
    input  start, divisor_zero, a_sign,
    output load_en, shift_a_en, sub_en, shift_q_en, restore_en,
    output busy, done, div_err, iter_count
  );

endinterface
`default_nettype wire

// File: rtl/rdiv_iter_counter.sv
`default_nettype none
// ============================================================================
// Module      : rdiv_iter_counter
// Description : Completed-iteration counter for the restoring-division
//               sequencer. Cleared at the start of an operation, stepped once
//               per finished iteration, flags the final iteration.
// Revision    : 1.0 - initial release
// ============================================================================
module rdiv_iter_counter import rdiv_pkg::*; #(
  parameter int WIDTH = RDIV_WIDTH,
  parameter int CNT_W = rdiv_cnt_w(WIDTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             inc,
  output logic      [CNT_W-1:0] iter_count,
  output logic                  last
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // Count register: clear wins over increment; holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign iter_count = r_count;
  // High while the iteration now in progress is the final one.
  assign last       = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/restoring_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : restoring_div_ctrl
// Description : Sequencer for a restoring-division datapath. On start it
//               loads the operands, then for WIDTH iterations issues shift,
//               subtract, quotient-bit insert and (if A went negative)
//               restore enables, finishing with a one-cycle done pulse.
//               Optional build macro RDIV_ZERO_CHECK_EN: a start with
//               divisor_zero set aborts straight from LOAD to DONE and
//               raises div_err.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_div_ctrl import rdiv_pkg::*; #(
  parameter int WIDTH = RDIV_WIDTH
) (
  input  wire logic clk,
  input  wire logic rst,
  rdiv_if.slave     bus
);

  localparam int CNT_W = rdiv_cnt_w(WIDTH);

  rdiv_state_t r_state;
  rdiv_state_t w_next;
  logic        w_last;
  logic        w_cnt_clear;
  logic        w_cnt_inc;
  logic        w_zero_abort;
  logic        w_accept;

  assign w_accept = (r_state == ST_IDLE) && bus.start;

`ifdef RDIV_ZERO_CHECK_EN
  logic r_zero;
  logic r_err;

  // Capture divisor_zero with the accepted start; error flag is cleared by
  // the next accepted start and set when the LOAD cycle aborts to DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_zero <= bus.divisor_zero;
        r_err  <= 1'b0;
      end else if ((r_state == ST_LOAD) && r_zero) begin
        r_err  <= 1'b1;
      end
    end
  end

  assign w_zero_abort = r_zero;
  assign bus.div_err  = r_err;
`else
  logic w_unused_zero;

  // Without the zero check the datapath's zero flag plays no role.
  assign w_unused_zero = bus.divisor_zero;
  assign w_zero_abort  = 1'b0;
  assign bus.div_err   = 1'b0;
`endif

  // An iteration ends when leaving QSET without a restore, or leaving RESTORE.
  assign w_cnt_clear = (r_state == ST_LOAD);
  assign w_cnt_inc   = ((r_state == ST_QSET) && !bus.a_sign) || (r_state == ST_RESTORE);

  rdiv_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (w_cnt_clear),
    .inc        (w_cnt_inc),
    .iter_count (bus.iter_count),
    .last       (w_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; start is only looked at in IDLE, so it is never queued.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.start) w_next = ST_LOAD;
      ST_LOAD:    w_next = w_zero_abort ? ST_DONE : ST_SHIFT;
      ST_SHIFT:   w_next = ST_SUB;
      ST_SUB:     w_next = ST_QSET;
      ST_QSET: begin
        if (bus.a_sign) begin
          w_next = ST_RESTORE;
        end else begin
          w_next = w_last ? ST_DONE : ST_SHIFT;
        end
      end
      ST_RESTORE: w_next = w_last ? ST_DONE : ST_SHIFT;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Moore output decode: exactly one datapath enable per working state.
  always_comb begin
    bus.load_en    = 1'b0;
    bus.shift_a_en = 1'b0;
    bus.sub_en     = 1'b0;
    bus.shift_q_en = 1'b0;
    bus.restore_en = 1'b0;
    bus.busy       = (r_state != ST_IDLE);
    bus.done       = (r_state == ST_DONE);
    case (r_state)
      ST_LOAD:    bus.load_en    = 1'b1;
      ST_SHIFT:   bus.shift_a_en = 1'b1;
      ST_SUB:     bus.sub_en     = 1'b1;
      ST_QSET:    bus.shift_q_en = 1'b1;
      ST_RESTORE: bus.restore_en = 1'b1;
      default:    ;
    endcase
  end

endmodule
`default_nettype wire
